// File: rtl/riscv_defines_pkg.sv
// Shared RISC-V core definitions.
// Holds the exception-PC target encodings used by the controller and the
// IF stage, plus the widths of the PC-select and vector-index fields.
package riscv_defines;

  localparam int EXC_PC_W  = 2;
  localparam int VEC_IDX_W = 5;

  localparam logic [EXC_PC_W-1:0] EXC_PC_EXC     = 2'b00;
  localparam logic [EXC_PC_W-1:0] EXC_PC_IRQ     = 2'b01;
  localparam logic [EXC_PC_W-1:0] EXC_PC_DBG_EXC = 2'b10;
  localparam logic [EXC_PC_W-1:0] EXC_PC_DBG     = 2'b11;

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter.
// Ports: clk, rst_n (async active-low), inc (count up by one),
//        clear (synchronous zero, wins over inc), count (current value).
// The count sticks at all-ones instead of wrapping.
module riscv_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       count <= '0;
    else if (clear)                   count <= '0;
    else if (inc && (count != '1))    count <= count + 1'b1;
  end

endmodule

// File: rtl/riscv_exc_ack_unit.sv
// Exception/interrupt acknowledge controller.
// Accepts a held-high request, drains outstanding LSU traffic, optionally
// parks the core for the debugger, then issues a single-cycle ack cycle
// (ack/pc_set/save_epc/flush) followed by one FLUSH cycle.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_i, trap_i, dbg_resume_i    request, debug trap, debugger resume
//   data_pending_i                 LSU transaction outstanding
//   pc_mux_i, vec_pc_mux_i         exception target select / vector index
//   ack_o, pc_set_o, save_epc_o    ack-cycle pulses
//   flush_o, halt_if_o, halt_id_o  pipeline control
//   exc_pc_mux_o, vec_pc_o         target/index to IF (bypassed on ack)
//   dbg_halted_o                   core parked for debugger
//   exc_cnt_o                      saturating count of acks
module riscv_exc_ack_unit
  import riscv_defines::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_i,
  output logic                 ack_o,
  input  logic [EXC_PC_W-1:0]  pc_mux_i,
  input  logic [VEC_IDX_W-1:0] vec_pc_mux_i,
  input  logic                 trap_i,
  input  logic                 dbg_resume_i,
  input  logic                 data_pending_i,
  output logic                 halt_if_o,
  output logic                 halt_id_o,
  output logic                 flush_o,
  output logic                 pc_set_o,
  output logic [EXC_PC_W-1:0]  exc_pc_mux_o,
  output logic [VEC_IDX_W-1:0] vec_pc_o,
  output logic                 save_epc_o,
  output logic                 dbg_halted_o,
  output logic [CNT_W-1:0]     exc_cnt_o
);

  // 3-bit encoding leaves spare codes; any of them falls back to IDLE.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    FLUSH    = 3'd2,
    DBG_WAIT = 3'd3
  } state_t;

  state_t state_q, state_d;
  // Set on debugger resume so the trap that caused the halt is not taken
  // again while the same request drains; cleared when the request is acked.
  logic   trap_mask_q, trap_mask_d;

  logic                 ack, flush, halt_if, halt_id, dbg_halted;
  logic [EXC_PC_W-1:0]  pc_mux_q;
  logic [VEC_IDX_W-1:0] vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      trap_mask_q <= 1'b0;
      pc_mux_q    <= EXC_PC_EXC;
      vec_q       <= '0;
    end else begin
      state_q     <= state_d;
      trap_mask_q <= trap_mask_d;
      if (ack) begin
        pc_mux_q <= pc_mux_i;
        vec_q    <= vec_pc_mux_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    trap_mask_d = trap_mask_q;
    ack         = 1'b0;
    flush       = 1'b0;
    halt_if     = 1'b0;
    halt_id     = 1'b0;
    dbg_halted  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (trap_i) begin
            state_d = DBG_WAIT;
          end else if (data_pending_i) begin
            halt_if = 1'b1;
            halt_id = 1'b1;
            state_d = DRAIN;
          end else begin
            ack     = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      DRAIN: begin
        halt_if = 1'b1;
        halt_id = 1'b1;
        if (!req_i) begin
          state_d     = IDLE;
          trap_mask_d = 1'b0;
        end else if (!data_pending_i) begin
          if (trap_i && !trap_mask_q) begin
            state_d = DBG_WAIT;
          end else begin
            ack     = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        halt_id = 1'b1;
        state_d = IDLE;
      end
      DBG_WAIT: begin
        dbg_halted = 1'b1;
        halt_if    = 1'b1;
        halt_id    = 1'b1;
        if (dbg_resume_i) begin
          state_d     = DRAIN;
          trap_mask_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        trap_mask_d = 1'b0;
      end
    endcase
    if (ack) begin
      flush       = 1'b1;
      trap_mask_d = 1'b0;
    end
  end

  // Outputs are forced low while reset is asserted, independent of clk.
  assign ack_o        = rst_n & ack;
  assign pc_set_o     = rst_n & ack;
  assign save_epc_o   = rst_n & ack;
  assign flush_o      = rst_n & flush;
  assign halt_if_o    = rst_n & halt_if;
  assign halt_id_o    = rst_n & halt_id;
  assign dbg_halted_o = rst_n & dbg_halted;

  // Zero-latency target: the IF stage sees the live select in the ack cycle.
  assign exc_pc_mux_o = ack_o ? pc_mux_i     : pc_mux_q;
  assign vec_pc_o     = ack_o ? vec_pc_mux_i : vec_q;

  riscv_sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ack_o),
    .clear (1'b0),
    .count (exc_cnt_o)
  );

endmodule

// File: tb/tb_riscv_exc_ack_unit.sv
// Directed bench for riscv_exc_ack_unit: expected outputs are queued as each
// step is driven and popped/compared on the following falling edge. A second
// instance with a 2-bit counter checks saturation on the same stimulus.
module tb_riscv_exc_ack_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, trap, resume, pending;
  logic [1:0] pc_mux;
  logic [4:0] vec;

  logic        ack, halt_if, halt_id, flush, pc_set, save_epc, dbg_halted;
  logic [1:0]  exc_pc_mux;
  logic [4:0]  vec_pc;
  logic [15:0] cnt;

  logic        ack2, halt_if2, halt_id2, flush2, pc_set2, save_epc2, dbg_halted2;
  logic [1:0]  exc_pc_mux2;
  logic [4:0]  vec_pc2;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;
  int cnt_model = 0;
  logic [29:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_exc_ack_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .ack_o(ack),
    .pc_mux_i(pc_mux), .vec_pc_mux_i(vec), .trap_i(trap),
    .dbg_resume_i(resume), .data_pending_i(pending),
    .halt_if_o(halt_if), .halt_id_o(halt_id), .flush_o(flush),
    .pc_set_o(pc_set), .exc_pc_mux_o(exc_pc_mux), .vec_pc_o(vec_pc),
    .save_epc_o(save_epc), .dbg_halted_o(dbg_halted), .exc_cnt_o(cnt)
  );

  riscv_exc_ack_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .ack_o(ack2),
    .pc_mux_i(pc_mux), .vec_pc_mux_i(vec), .trap_i(trap),
    .dbg_resume_i(resume), .data_pending_i(pending),
    .halt_if_o(halt_if2), .halt_id_o(halt_id2), .flush_o(flush2),
    .pc_set_o(pc_set2), .exc_pc_mux_o(exc_pc_mux2), .vec_pc_o(vec_pc2),
    .save_epc_o(save_epc2), .dbg_halted_o(dbg_halted2), .exc_cnt_o(cnt2)
  );

  function automatic logic [29:0] pack_exp(logic a, logic f, logic hif, logic hid,
                                           logic d, logic [1:0] m, logic [4:0] v,
                                           logic [15:0] c);
    return {a, a, a, f, hif, hid, d, m, v, c};
  endfunction

  task automatic compare_out(input string tag);
    logic [29:0] e, o;
    logic [1:0]  e2;
    e = exp_q.pop_front();
    o = {ack, pc_set, save_epc, flush, halt_if, halt_id, dbg_halted,
         exc_pc_mux, vec_pc, cnt};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    e2 = (cnt_model > 3) ? 2'd3 : 2'(cnt_model);
    checks++;
    assert (cnt2 === e2) else begin
      failures++;
      $error("FAIL %s_cnt2 observed=%0d expected=%0d", tag, cnt2, e2);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic t,
                      input logic p, input logic res,
                      input logic [1:0] m, input logic [4:0] v,
                      input logic e_ack, input logic e_fl, input logic e_hif,
                      input logic e_hid, input logic e_dbg,
                      input logic [1:0] e_m, input logic [4:0] e_v);
    req = r; trap = t; pending = p; resume = res; pc_mux = m; vec = v;
    exp_q.push_back(pack_exp(e_ack, e_fl, e_hif, e_hid, e_dbg, e_m, e_v,
                             16'(cnt_model)));
    @(negedge clk);
    compare_out(tag);
    if (e_ack) cnt_model++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 0; trap = 0; resume = 0; pending = 0;
    pc_mux = 2'b00; vec = 5'd0;
    #3;
    exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 2'b00, 5'd0, 16'd0));
    compare_out("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      step("idle", 0,0,0,0, 2'b00,5'd0, 0,0,0,0,0, 2'b00,5'd0);

    // zero-latency ack, then FLUSH with held target
    step("ack1",   1,0,0,0, 2'b01,5'd7, 1,1,0,0,0, 2'b01,5'd7);
    step("flush1", 0,0,0,0, 2'b11,5'd3, 0,1,0,1,0, 2'b01,5'd7);
    step("idle1",  0,0,0,0, 2'b11,5'd3, 0,0,0,0,0, 2'b01,5'd7);

    // drain three pending cycles
    for (int i = 0; i < 3; i++)
      step("drain", 1,0,1,0, 2'b10,5'd9, 0,0,1,1,0, 2'b01,5'd7);
    step("drn_ack", 1,0,0,0, 2'b10,5'd9, 1,1,1,1,0, 2'b10,5'd9);
    step("drn_fl",  0,0,0,0, 2'b10,5'd9, 0,1,0,1,0, 2'b10,5'd9);

    // debug trap, resume ten cycles later, trap ignored on the way out
    step("trap0", 1,1,0,0, 2'b11,5'd31, 0,0,0,0,0, 2'b10,5'd9);
    for (int i = 0; i < 9; i++)
      step("dbgw", 1,1,0,0, 2'b11,5'd31, 0,0,1,1,1, 2'b10,5'd9);
    step("resume",  1,1,0,1, 2'b11,5'd31, 0,0,1,1,1, 2'b10,5'd9);
    step("dbg_ack", 1,1,0,0, 2'b11,5'd31, 1,1,1,1,0, 2'b11,5'd31);
    step("dbg_fl",  0,0,0,0, 2'b11,5'd31, 0,1,0,1,0, 2'b11,5'd31);

    // back-to-back: ack, FLUSH, ack, ...
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step("b2b_ack", 1,0,0,0, 2'b00,5'd1, 1,1,0,0,0, 2'b00,5'd1);
      else            step("b2b_fl",  1,0,0,0, 2'b00,5'd1, 0,1,0,1,0, 2'b00,5'd1);
    end
    step("idle2", 0,0,0,0, 2'b00,5'd1, 0,0,0,0,0, 2'b00,5'd1);

    // trap arriving while draining goes to debugger instead of acking
    step("td0",    1,0,1,0, 2'b01,5'd2, 0,0,1,1,0, 2'b00,5'd1);
    step("td1",    1,1,0,0, 2'b01,5'd2, 0,0,1,1,0, 2'b00,5'd1);
    step("td_dbg", 1,1,0,1, 2'b01,5'd2, 0,0,1,1,1, 2'b00,5'd1);
    step("td_ack", 1,1,0,0, 2'b01,5'd2, 1,1,1,1,0, 2'b01,5'd2);
    step("td_fl",  0,0,0,0, 2'b01,5'd2, 0,1,0,1,0, 2'b01,5'd2);

    // asynchronous reset in the middle of DRAIN
    step("rd0", 1,0,1,0, 2'b10,5'd4, 0,0,1,1,0, 2'b01,5'd2);
    step("rd1", 1,0,1,0, 2'b10,5'd4, 0,0,1,1,0, 2'b01,5'd2);
    rst_n = 1'b0;
    #1;
    cnt_model = 0;
    exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 2'b00, 5'd0, 16'd0));
    compare_out("rst_drain");
    req = 0; pending = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst", 1,0,0,0, 2'b10,5'd4, 1,1,0,0,0, 2'b10,5'd4);
    step("post_fl",  0,0,0,0, 2'b10,5'd4, 0,1,0,1,0, 2'b10,5'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_exc_ack_unit.md
RISCV_EXC_ACK_UNIT -- requirements
Module: riscv_exc_ack_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the accepted-exception counter.
REQ-002 SHALL have clk  in  1  core clock, all state on rising edge.
REQ-003 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_i  in  1  exception/interrupt request, held high until acknowledged.
REQ-005 SHALL have ack_o  out  1  acknowledge, one-cycle pulse per accepted request.
REQ-006 SHALL have pc_mux_i  in  2  exception target select, EXC_PC_* encoding.
REQ-007 SHALL have vec_pc_mux_i  in  5  vectored-interrupt handler index.
REQ-008 SHALL have trap_i  in  1  debug trap request accompanying req_i.
REQ-009 SHALL have dbg_resume_i  in  1  debugger resume pulse.
REQ-010 SHALL have data_pending_i  in  1  LSU transaction outstanding.
REQ-011 SHALL have halt_if_o  out  1  stall fetch.
REQ-012 SHALL have halt_id_o  out  1  stall decode.
REQ-013 SHALL have flush_o  out  1  kill IF/ID contents.
REQ-014 SHALL have pc_set_o  out  1  load exception PC into IF stage.
REQ-015 SHALL have exc_pc_mux_o  out  2  target select to IF stage.
REQ-016 SHALL have vec_pc_o  out  5  handler index to IF stage.
REQ-017 SHALL have save_epc_o  out  1  write EPC from ID-stage PC.
REQ-018 SHALL have dbg_halted_o  out  1  core halted for debugger.
REQ-019 SHALL have exc_cnt_o  out  CNT_W  saturating count of acknowledged requests.

Function
REQ-020 SHALL implement FSM states IDLE, DRAIN, FLUSH, DBG_WAIT.
REQ-021 IDLE, req_i=0: all pulse/halt outputs 0, state held.
REQ-022 IDLE, req_i=1, trap_i=1: no ack; next DBG_WAIT (trap has priority over drain).
REQ-023 IDLE, req_i=1, trap_i=0, data_pending_i=1: no ack, halt_if_o=halt_id_o=1; next DRAIN.
REQ-024 IDLE, req_i=1, trap_i=0, data_pending_i=0: ack cycle same cycle (zero latency); next FLUSH.
REQ-025 Ack cycle: ack_o=pc_set_o=save_epc_o=flush_o=1 together, exactly one cycle.
REQ-026 DRAIN: halt_if_o=halt_id_o=1; ack cycle in first cycle with data_pending_i=0; next FLUSH.
REQ-027 DRAIN with trap_i=1 and data_pending_i=0: next DBG_WAIT, no ack.
REQ-028 FLUSH: flush_o=halt_id_o=1, ack_o=0 even if req_i=1; next IDLE unconditionally.
REQ-029 DBG_WAIT: dbg_halted_o=halt_if_o=halt_id_o=1; on dbg_resume_i next DRAIN, trap_i ignored for that request.
REQ-030 Back-to-back requests: earliest second ack is two cycles after first (ack, FLUSH, ack).
REQ-031 exc_pc_mux_o/vec_pc_o SHALL bypass pc_mux_i/vec_pc_mux_i in ack cycle, else show registered copy captured at last ack.
REQ-032 exc_cnt_o SHALL increment by 1 per ack cycle, saturate at all-ones, never wrap.
REQ-033 Illegal state encoding SHALL return to IDLE next cycle, no outputs asserted.

Reset
REQ-034 rst_n low SHALL force IDLE, exc_cnt_o=0, captured pc_mux/vec regs=0, all 1-bit outputs 0, regardless of clk.
REQ-035 Reset mid-DRAIN/DBG_WAIT SHALL drop the request without ack; re-evaluated from IDLE after release.

Structure
REQ-036 EXC_PC_* encodings SHALL come from the shared riscv_defines package; FSM enum stays local.
REQ-037 Counter SHALL be sub-module riscv_sat_counter (parameter width, inc, clear, count).
REQ-038 Outputs SHALL be combinational from state plus inputs; only state, counter and capture regs sequential.

Verification
REQ-039 req_i=1, pc_mux_i=2'b01, vec=5'd7, pending=0 at cycle 5 -> ack_o, pc_set_o at cycle 5, exc_pc_mux_o=01, vec_pc_o=7 then held; FLUSH cycle 6; exc_cnt_o=1.
REQ-040 req_i=1 with data_pending_i=1 for 3 cycles -> halts 3 cycles, ack in 4th cycle, then FLUSH.
REQ-041 req_i=1, trap_i=1 -> dbg_halted_o until dbg_resume_i at cycle +10; ack next cycle if pending=0.
REQ-042 req_i held high 6 cycles, pending=0 -> acks at cycles 0,2,4, flush_o all 6 cycles.
REQ-043 CNT_W=2, 5 acks -> exc_cnt_o 1,2,3,3,3.
REQ-044 rst_n low during DRAIN -> all outputs 0 immediately, no ack, exc_cnt_o=0.
